// File: rtl/camera_axi_writer_if.sv
// AXI4 write-channel bundle between the camera frame writer (master) and the memory port (slave).
interface camera_axi_writer_if #(
   parameter int AXI4_ADDRESS_WIDTH = 32
);
   logic [AXI4_ADDRESS_WIDTH-1:0] awaddr;
   logic [7:0]                    awlen;
   logic [2:0]                    awsize;
   logic [1:0]                    awburst;
   logic                          awvalid;
   logic                          awready;
   logic [31:0]                   wdata;
   logic [3:0]                    wstrb;
   logic                          wlast;
   logic                          wvalid;
   logic                          wready;
   logic [1:0]                    bresp;
   logic                          bvalid;
   logic                          bready;

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/camera_axi_writer.sv
// Buffers packed pixel words in a small FIFO and writes them to the frame buffer as AXI4 INCR bursts,
// flushing a short burst at frame end and reporting frame completion, overflow and bus errors.
//
// state  | meaning
// S_IDLE | waiting for a full burst of words, a frame-end flush, or frame completion
// S_ADDR | awvalid held with address/length stable until awready
// S_DATA | streaming FIFO head onto the W channel, wlast on the final beat
// S_RESP | bready held until the write response arrives
module camera_axi_writer #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int FIFO_DEPTH         = 16,
    parameter int BURST_LEN          = 8
) (
    input  logic                          pclk,
    input  logic                          rst_n,
    input  logic                          vsync,
    input  logic                          word_valid,
    input  logic [31:0]                   word_data,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] base_addr,
    camera_axi_writer_if.master           m,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          axi_err,
    output logic [23:0]                   words_written
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int BLW = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t                        state;
    logic [31:0]                   mem [FIFO_DEPTH];
    logic [PW:0]                   wr_ptr, rd_ptr, count;
    logic                          full, word_in, push, pop;
    logic                          vsync_d, vsync_rise, flush_pending, load_base;
    logic [AXI4_ADDRESS_WIDTH-1:0] addr, awaddr_q;
    logic [7:0]                    awlen_q;
    logic                          awvalid_q, wvalid_q, wlast_q, bready_q;
    logic [BLW-1:0]                beats, beats_left;
    logic [24:0]                   ww_sum;

    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == (PW+1)'(FIFO_DEPTH));
    // Words during vsync belong to the blanking interval, not to any frame
    assign word_in    = word_valid && !vsync;
    assign pop        = wvalid_q && m.wready;
    assign push       = word_in && (!full || pop);
    assign vsync_rise = vsync && !vsync_d;
    assign ww_sum     = {1'b0, words_written} + 25'(beats);

    assign m.awaddr  = awaddr_q;
    assign m.awlen   = awlen_q;
    assign m.awsize  = 3'b010;
    assign m.awburst = 2'b01;
    assign m.awvalid = awvalid_q;
    assign m.wdata   = mem[rd_ptr[PW-1:0]];
    assign m.wstrb   = 4'hF;
    assign m.wlast   = wlast_q;
    assign m.wvalid  = wvalid_q;
    assign m.bready  = bready_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            vsync_d  <= 1'b0;
        end else begin
            vsync_d <= vsync;
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= word_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (word_in && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            addr          <= '0;
            load_base     <= 1'b1;
            flush_pending <= 1'b0;
            frame_done    <= 1'b0;
            axi_err       <= 1'b0;
            words_written <= '0;
            awaddr_q      <= '0;
            awlen_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            wlast_q       <= 1'b0;
            bready_q      <= 1'b0;
            beats         <= '0;
            beats_left    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (load_base) begin
                addr      <= base_addr;
                load_base <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (count >= (PW+1)'(BURST_LEN)) begin
                        beats      <= BLW'(BURST_LEN);
                        beats_left <= BLW'(BURST_LEN);
                        awlen_q    <= 8'(BURST_LEN - 1);
                        awaddr_q   <= addr;
                        awvalid_q  <= 1'b1;
                        state      <= S_ADDR;
                    end else if (flush_pending && count != '0) begin
                        beats      <= BLW'(count);
                        beats_left <= BLW'(count);
                        awlen_q    <= 8'(count) - 8'd1;
                        awaddr_q   <= addr;
                        awvalid_q  <= 1'b1;
                        state      <= S_ADDR;
                    end else if (flush_pending) begin
                        frame_done    <= 1'b1;
                        flush_pending <= 1'b0;
                        addr          <= base_addr;
                        words_written <= '0;
                    end
                end
                S_ADDR: begin
                    if (m.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        wlast_q   <= (beats == BLW'(1));
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (m.wready) begin
                        if (wlast_q) begin
                            wvalid_q <= 1'b0;
                            wlast_q  <= 1'b0;
                            bready_q <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                            wlast_q    <= (beats_left == BLW'(2));
                        end
                    end
                end
                S_RESP: begin
                    if (m.bvalid) begin
                        bready_q      <= 1'b0;
                        addr          <= addr + AXI4_ADDRESS_WIDTH'({beats, 2'b00});
                        words_written <= ww_sum[24] ? 24'hFF_FFFF : ww_sum[23:0];
                        if (m.bresp != 2'b00) axi_err <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // A new frame end must survive a same-cycle clear of the previous one
            if (vsync_rise) flush_pending <= 1'b1;
        end
    end
endmodule
